// File: rtl/cache_arbiter.sv
// Two-requester arbiter sharing a single L2 port between icache and dcache.
// Round-robin on ties, one transaction in flight, one-cycle release gap between grants.
module cache_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              icache_l2_read,
  input  logic [ADDR_W-1:0] icache_l2_addr,
  output logic              icache_l2_resp,
  output logic [LINE_W-1:0] icache_l2_rdata,
  input  logic              dcache_l2_read,
  input  logic              dcache_l2_write,
  input  logic [ADDR_W-1:0] dcache_l2_addr,
  input  logic [LINE_W-1:0] dcache_l2_wdata,
  output logic              dcache_l2_resp,
  output logic [LINE_W-1:0] dcache_l2_rdata,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic              l2_resp,
  input  logic [LINE_W-1:0] l2_rdata
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StServeI  = 2'd1;
  localparam logic [1:0] StServeD  = 2'd2;
  localparam logic [1:0] StRelease = 2'd3;

  // Clears the byte offset within a 16-byte line.
  localparam logic [ADDR_W-1:0] LineMask = ~(ADDR_W'(15));

  logic [1:0]        r_state;
  logic              r_last_d;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic              r_write;

  logic [1:0] w_state_d;
  logic       w_i_req;
  logic       w_d_req;
  logic       w_grant_i;
  logic       w_grant_d;
  logic       w_serving;

  assign w_i_req   = icache_l2_read;
  assign w_d_req   = dcache_l2_read | dcache_l2_write;
  assign w_serving = (r_state == StServeI) || (r_state == StServeD);

  always_comb begin
    w_state_d = r_state;
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    case (r_state)
      StIdle: begin
        // On a tie the requester not served last wins.
        if (w_i_req && (!w_d_req || r_last_d)) begin
          w_grant_i = 1'b1;
          w_state_d = StServeI;
        end else if (w_d_req) begin
          w_grant_d = 1'b1;
          w_state_d = StServeD;
        end
      end
      StServeI, StServeD: begin
        if (l2_resp) w_state_d = StRelease;
      end
      StRelease: w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StIdle;
      r_last_d <= 1'b1;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_write  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_grant_i) begin
        r_addr   <= icache_l2_addr;
        r_wdata  <= '0;
        r_write  <= 1'b0;
        r_last_d <= 1'b0;
      end else if (w_grant_d) begin
        r_addr   <= dcache_l2_addr;
        r_wdata  <= dcache_l2_wdata;
        r_write  <= dcache_l2_write;
        r_last_d <= 1'b1;
      end
    end
  end

  always_comb begin
    l2_read         = 1'b0;
    l2_write        = 1'b0;
    l2_addr         = '0;
    l2_wdata        = '0;
    icache_l2_resp  = 1'b0;
    icache_l2_rdata = '0;
    dcache_l2_resp  = 1'b0;
    dcache_l2_rdata = '0;
    if (w_serving) begin
      l2_read  = ~r_write;
      l2_write = r_write;
      l2_addr  = r_addr & LineMask;
      l2_wdata = r_wdata;
    end
    // A reset arriving alongside l2_resp abandons the transaction silently.
    if (l2_resp && !reset) begin
      if (r_state == StServeI) begin
        icache_l2_resp  = 1'b1;
        icache_l2_rdata = l2_rdata;
      end else if (r_state == StServeD) begin
        dcache_l2_resp  = 1'b1;
        dcache_l2_rdata = l2_rdata;
      end
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: stimulus pushes expected L2 requests and
// responses into queues; a negedge monitor pops and compares them.
module tb_cache_arbiter;

  localparam int AW = 16;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          icache_l2_read;
  logic [AW-1:0] icache_l2_addr;
  logic          icache_l2_resp;
  logic [LW-1:0] icache_l2_rdata;
  logic          dcache_l2_read;
  logic          dcache_l2_write;
  logic [AW-1:0] dcache_l2_addr;
  logic [LW-1:0] dcache_l2_wdata;
  logic          dcache_l2_resp;
  logic [LW-1:0] dcache_l2_rdata;
  logic          l2_read;
  logic          l2_write;
  logic [AW-1:0] l2_addr;
  logic [LW-1:0] l2_wdata;
  logic          l2_resp;
  logic [LW-1:0] l2_rdata;

  cache_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk             (clk),
    .reset           (reset),
    .icache_l2_read  (icache_l2_read),
    .icache_l2_addr  (icache_l2_addr),
    .icache_l2_resp  (icache_l2_resp),
    .icache_l2_rdata (icache_l2_rdata),
    .dcache_l2_read  (dcache_l2_read),
    .dcache_l2_write (dcache_l2_write),
    .dcache_l2_addr  (dcache_l2_addr),
    .dcache_l2_wdata (dcache_l2_wdata),
    .dcache_l2_resp  (dcache_l2_resp),
    .dcache_l2_rdata (dcache_l2_rdata),
    .l2_read         (l2_read),
    .l2_write        (l2_write),
    .l2_addr         (l2_addr),
    .l2_wdata        (l2_wdata),
    .l2_resp         (l2_resp),
    .l2_rdata        (l2_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } req_t;

  typedef struct {
    bit            is_d;
    logic [LW-1:0] data;
  } resp_t;

  req_t  exp_req_q[$];
  resp_t exp_resp_q[$];
  int    total = 0;
  int    bad = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic any_out();
    return |{icache_l2_resp, icache_l2_rdata, dcache_l2_resp, dcache_l2_rdata,
             l2_read, l2_write, l2_addr, l2_wdata};
  endfunction

  // Monitor: checks every L2 request and every response against the queues.
  req_t  cur;
  resp_t er;
  logic  prev_req = 1'b0;
  always @(negedge clk) begin
    if (l2_read | l2_write) begin
      if (!prev_req) begin
        if (exp_req_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_l2_req: got addr %h want none", l2_addr);
        end else begin
          cur = exp_req_q.pop_front();
        end
      end
      chk("l2_read", l2_read, !cur.wr);
      chk("l2_write", l2_write, cur.wr);
      chk("l2_addr", l2_addr, cur.addr);
      chk("l2_wdata", l2_wdata, cur.wdata);
    end
    if (icache_l2_resp || dcache_l2_resp) begin
      chk("resp_exclusive", icache_l2_resp & dcache_l2_resp, 0);
      if (exp_resp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_resp: got i=%0b d=%0b want none", icache_l2_resp,
                 dcache_l2_resp);
      end else begin
        er = exp_resp_q.pop_front();
        chk("resp_is_d", dcache_l2_resp, er.is_d);
        chk("resp_rdata", er.is_d ? dcache_l2_rdata : icache_l2_rdata, er.data);
        chk("other_rdata", er.is_d ? icache_l2_rdata : dcache_l2_rdata, 0);
      end
    end
    prev_req = l2_read | l2_write;
  end

  task automatic push_req(input bit wr, input logic [AW-1:0] addr, input logic [LW-1:0] wd);
    req_t r;
    r.wr = wr; r.addr = addr; r.wdata = wd;
    exp_req_q.push_back(r);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    icache_l2_read = 0; icache_l2_addr = '0;
    dcache_l2_read = 0; dcache_l2_write = 0; dcache_l2_addr = '0; dcache_l2_wdata = '0;
    l2_resp = 0; l2_rdata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1 chk("reset_outputs_zero", any_out(), 0);
  endtask

  // Starts in an IDLE cycle with requests driven; ends two ticks into the next IDLE cycle.
  task automatic serve(input bit is_d, input int waits, input bit mutate,
                       input logic [LW-1:0] rd);
    resp_t r;
    @(posedge clk); #1;
    if (mutate) begin
      dcache_l2_addr  = 16'hFFFF;
      dcache_l2_wdata = '1;
    end
    #1 chk("req_active", l2_read | l2_write, 1);
    repeat (waits) begin
      @(posedge clk); #2;
      chk("wait_req_held", l2_read | l2_write, 1);
      chk("wait_no_resp", icache_l2_resp | dcache_l2_resp, 0);
    end
    r.is_d = is_d; r.data = rd;
    exp_resp_q.push_back(r);
    l2_resp = 1'b1; l2_rdata = rd;
    @(posedge clk); #1;
    l2_resp = 1'b0; l2_rdata = '0;
    #1 chk("release_quiet", any_out(), 0);
    @(posedge clk); #2;
    chk("idle_quiet", any_out(), 0);
  endtask

  initial begin
    do_reset();

    // Single icache fill.
    icache_l2_read = 1; icache_l2_addr = 16'h1234;
    push_req(0, 16'h1230, '0);
    serve(0, 0, 0, {16{8'hA5}});
    icache_l2_read = 0;

    // Three ties after reset: I, D, I.
    do_reset();
    icache_l2_read = 1; icache_l2_addr = 16'h1000;
    dcache_l2_read = 1; dcache_l2_addr = 16'h2008;
    push_req(0, 16'h1000, '0);
    serve(0, 0, 0, {4{32'h11111111}});
    push_req(0, 16'h2000, '0);
    serve(1, 1, 0, {4{32'h22222222}});
    push_req(0, 16'h1000, '0);
    serve(0, 0, 0, {4{32'h33333333}});
    icache_l2_read = 0; dcache_l2_read = 0;

    // Writeback with inputs changing mid-transaction.
    @(posedge clk); #1;
    dcache_l2_write = 1; dcache_l2_addr = 16'h0040;
    dcache_l2_wdata = {2{64'h0123456789ABCDEF}};
    push_req(1, 16'h0040, {2{64'h0123456789ABCDEF}});
    serve(1, 3, 1, {4{32'hCAFEF00D}});
    dcache_l2_write = 0;

    // Long L2 stall, then a stray l2_resp in IDLE.
    @(posedge clk); #1;
    icache_l2_read = 1; icache_l2_addr = 16'h5678;
    push_req(0, 16'h5670, '0);
    serve(0, 20, 0, {4{32'hDEADBEEF}});
    icache_l2_read = 0;
    l2_resp = 1; l2_rdata = {4{32'h77777777}};
    #1 chk("idle_resp_ignored", any_out(), 0);
    @(posedge clk); #1 l2_resp = 0; l2_rdata = '0;
    #1 chk("idle_after_stray", any_out(), 0);

    // Reset during SERVE_D abandons it; next tie goes to the icache.
    do_reset();
    dcache_l2_read = 1; dcache_l2_addr = 16'h3000;
    push_req(0, 16'h3000, '0);
    @(posedge clk); #1;
    reset = 1; dcache_l2_read = 0;
    #1 chk("serve_d_active", l2_read, 1);
    @(posedge clk); #1;
    reset = 0; l2_resp = 1; l2_rdata = {4{32'h99999999}};
    #1 chk("post_reset_resp_ignored", any_out(), 0);
    @(posedge clk); #1 l2_resp = 0; l2_rdata = '0;
    icache_l2_read = 1; icache_l2_addr = 16'h4444;
    dcache_l2_read = 1; dcache_l2_addr = 16'h5555;
    push_req(0, 16'h4440, '0);
    serve(0, 0, 0, {4{32'h44444444}});
    icache_l2_read = 0; dcache_l2_read = 0;

    repeat (3) @(posedge clk);
    chk("req_queue_drained", exp_req_q.size(), 0);
    chk("resp_queue_drained", exp_resp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning the byte address width.
REQ-002 The block SHALL have parameter LINE_W, default 128, meaning the cache line width in bits (16 bytes).
REQ-003 The block SHALL have one clock and a synchronous active-high reset: clk, input, 1, rising-edge clock for all state.
REQ-004 reset, input, 1, synchronous active-high reset.
REQ-005 icache_l2_read, input, 1, icache miss fill request; level, held until icache_l2_resp.
REQ-006 icache_l2_addr, input, ADDR_W, icache miss address.
REQ-007 icache_l2_resp, output, 1, one-cycle completion to icache.
REQ-008 icache_l2_rdata, output, LINE_W, fill line to icache; valid while icache_l2_resp=1.
REQ-009 dcache_l2_read / dcache_l2_write, input, 1 each, dcache fill or writeback request; level, held until dcache_l2_resp; never both 1.
REQ-010 dcache_l2_addr, input, ADDR_W; dcache_l2_wdata, input, LINE_W, writeback line.
REQ-011 dcache_l2_resp, output, 1; dcache_l2_rdata, output, LINE_W; semantics as for the icache.
REQ-012 l2_read / l2_write, output, 1 each, request to the single L2 port.
REQ-013 l2_addr, output, ADDR_W; l2_wdata, output, LINE_W.
REQ-014 l2_resp, input, 1, L2 completion pulse; l2_rdata, input, LINE_W, valid while l2_resp=1.

Function
REQ-015 The FSM SHALL have states IDLE, SERVE_I, SERVE_D and RELEASE.
REQ-016 IDLE with only the icache requesting SHALL go to SERVE_I; with only the dcache requesting (read or write) SHALL go to SERVE_D; with neither SHALL stay in IDLE.
REQ-017 IDLE with both requesting SHALL grant the requester not served last, using register last_d (1 = dcache served last).
- icache wins when last_d=1.
- dcache wins when last_d=0.
REQ-018 On entry to SERVE_x, the block SHALL latch the winner's address, write data and read/write type into internal registers.
REQ-019 On entry to SERVE_x, last_d SHALL update: 1 for SERVE_D, 0 for SERVE_I.
REQ-020 In SERVE_I/SERVE_D, the L2 outputs SHALL be driven only from the latched registers.
- l2_addr = latched address with bits [3:0] forced to 0.
- l2_read or l2_write is asserted per the latched type; l2_read=l2_write=0 in all other states.
REQ-021 In SERVE_x with l2_resp=1, the block SHALL assert x's resp the same cycle and pass l2_rdata combinationally to x's rdata, then go to RELEASE.
REQ-022 In SERVE_x with l2_resp=0, the block SHALL stay in SERVE_x.
REQ-023 RELEASE SHALL last exactly one cycle, assert no resp and no L2 request, and return to IDLE; this lets the served requester drop its level request.
REQ-024 Minimum latency from request to resp SHALL be 2 cycles: IDLE to SERVE at edge 1, and l2_resp arriving in the first SERVE cycle.
REQ-025 Back-to-back service SHALL take at least 3 cycles from one resp to the next L2 request.
REQ-026 l2_resp arriving in IDLE or RELEASE SHALL be ignored, with no resp and no state change.
REQ-027 A requester that drops its request mid-SERVE SHALL NOT abort the L2 transaction; the resp pulse SHALL still be issued on l2_resp.
REQ-028 Unserved rdata outputs SHALL be 0; icache_l2_resp and dcache_l2_resp SHALL never be 1 in the same cycle.
REQ-029 Address and write data changes at the inputs during SERVE_x SHALL NOT affect l2_addr or l2_wdata.

Reset
REQ-030 With reset=1 at a rising edge, the block SHALL set state=IDLE and last_d=1 (icache wins the first tie), and clear the latched address, data and type to 0.
REQ-031 While in IDLE after reset, every output SHALL be 0.
REQ-032 Reset asserted mid-SERVE SHALL abandon the transaction; no resp SHALL be issued for it, and a later l2_resp SHALL be ignored.

Verification
REQ-033 Scenario: after reset, icache_l2_read=1, icache_l2_addr=0x1234 -> next cycle l2_read=1, l2_addr=0x1230; with l2_resp=1 and l2_rdata=0xA5..A5 -> icache_l2_resp=1 with the same data that cycle, then RELEASE, then IDLE.
REQ-034 Scenario: icache and dcache requesting together after reset -> icache served first; both still requesting afterward -> dcache served next; a third tie -> icache again.
REQ-035 Scenario: dcache_l2_write=1, addr=0x0040, wdata=0x0123..; inputs changed to 0xFFFF and all-ones during SERVE_D -> l2_write=1, l2_addr=0x0040, wdata unchanged until l2_resp; l2_read=0 throughout.
REQ-036 Scenario: l2_resp held 0 for 20 cycles in SERVE_I -> state stays SERVE_I, no resp; l2_resp pulsed in IDLE -> no resp.
REQ-037 Scenario: reset pulsed during SERVE_D, then l2_resp=1 -> no dcache_l2_resp, all outputs 0, state IDLE, and next tie won by the icache.
